// File: rtl/core_mc_pkg.sv
// core_pkg: opcode and FSM state encodings shared by the core, its ALU and its bus interface.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package core_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_STA = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7,
    OP_LDI = 4'h8,
    OP_JMP = 4'h9,
    OP_JZ  = 4'hA,
    OP_JC  = 4'hB,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Opcodes that need a data-memory access before they can complete.
  function automatic logic is_mem_op(input opcode_e op);
    case (op)
      OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_mem_op = 1'b1;
      default:                                               is_mem_op = 1'b0;
    endcase
  endfunction

  // The three unassigned encodings C, D and E.
  function automatic logic is_illegal_op(input opcode_e op);
    logic [OP_W-1:0] w_raw;
    w_raw = op;
    is_illegal_op = (w_raw == 4'hC) || (w_raw == 4'hD) || (w_raw == 4'hE);
  endfunction

endpackage

// File: rtl/core_mc_if.sv
// core_mc_if: instruction-ROM and data-memory bus of core_mc.
// Latency: ROM data returns one cycle after imem_addr; a data access completes on the cycle ack is seen.
// Backpressure: dmem_req holds addr/we/wdata stable until dmem_ack is sampled with clk_en high.
interface core_mc_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  import core_pkg::*;

  logic [ADDR_W-1:0]      imem_addr;
  logic [OP_W+ADDR_W-1:0] imem_rdata;
  logic                   dmem_req;
  logic                   dmem_we;
  logic [ADDR_W-1:0]      dmem_addr;
  logic [DATA_W-1:0]      dmem_wdata;
  logic [DATA_W-1:0]      dmem_rdata;
  logic                   dmem_ack;

  // Core side.
  modport master (
    output imem_addr,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  // Memory side.
  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/core_mc_alu.sv
// core_alu: accumulator ALU; loads pass operand b straight through.
// Latency: combinational.
// Backpressure: none.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] w_wide;

  // Result select; carry is the extra bit of the widened sum/difference (borrow for SUB).
  always_comb begin
    w_wide = '0;
    y      = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        w_wide = {1'b0, a} + {1'b0, b};
        y      = w_wide[DATA_W-1:0];
        carry  = w_wide[DATA_W];
      end
      OP_SUB: begin
        w_wide = {1'b0, a} - {1'b0, b};
        y      = w_wide[DATA_W-1:0];
        carry  = w_wide[DATA_W];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = b;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/core_mc.sv
// core_mc: multi-cycle accumulator core with external ROM and variable-latency data memory.
// Latency: 3 cycles per non-memory instruction, 4 + wait states per memory instruction.
// Backpressure: waits in MEM until dmem_ack is seen with clk_en high; clk_en low freezes all state.
module core_mc
  import core_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  core_mc_if.master         bus,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              illegal
);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [ADDR_W-1:0]      r_pc;
  logic [DATA_W-1:0]      r_acc;
  logic                   r_z;
  logic                   r_c;
  logic [OP_W+ADDR_W-1:0] r_ir;

  opcode_e           w_op;
  logic [ADDR_W-1:0] w_operand;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_y;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_req;
  logic              w_we;
  logic              w_halted;
  logic              w_illegal;
  logic              w_mem_done;

  assign w_op      = opcode_e'(r_ir[OP_W+ADDR_W-1 -: OP_W]);
  assign w_operand = r_ir[ADDR_W-1:0];

  // LDI immediate: zero-extend a narrow address field, or keep its low bits when wider.
  generate
    if (DATA_W > ADDR_W) begin : g_imm_ext
      assign w_imm = {{(DATA_W-ADDR_W){1'b0}}, w_operand};
    end else begin : g_imm_trunc
      assign w_imm = w_operand[DATA_W-1:0];
    end
  endgenerate

  // Memory ops take b from the bus, LDI from the instruction.
  assign w_alu_b    = (r_state == S_MEM) ? bus.dmem_rdata : w_imm;
  assign w_mem_done = (r_state == S_MEM) && bus.dmem_ack;

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (w_op),
    .a     (r_acc),
    .b     (w_alu_b),
    .y     (w_alu_y),
    .carry (w_alu_c),
    .zero  (w_alu_z)
  );

  // State register; holds while clk_en is low so an ack seen then is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else if (clk_en) begin
      r_state <= w_next_state;
    end
  end

  // Next state and state-decoded outputs; reset lands in FETCH, so req/we drop at once.
  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_halted     = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        w_illegal = is_illegal_op(w_op);
        if (w_op == OP_HLT) begin
          w_next_state = S_HALT;
        end else if (is_mem_op(w_op)) begin
          w_next_state = S_MEM;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEM: begin
        w_req = 1'b1;
        w_we  = (w_op == OP_STA);
        if (bus.dmem_ack) begin
          w_next_state = S_FETCH;
        end
      end
      S_HALT:  w_halted     = 1'b1;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Architectural registers: ir/pc in DECODE, LDI and branches in EXEC, ALU ops on ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= RESET_PC;
      r_acc <= '0;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
      r_ir  <= '0;
    end else if (clk_en) begin
      case (r_state)
        S_DECODE: begin
          r_ir <= bus.imem_rdata;
          r_pc <= r_pc + ADDR_W'(1);
        end
        S_EXEC: begin
          case (w_op)
            OP_LDI: begin
              r_acc <= w_alu_y;
              r_z   <= w_alu_z;
            end
            OP_JMP:  r_pc <= w_operand;
            OP_JZ:   if (r_z) r_pc <= w_operand;
            OP_JC:   if (r_c) r_pc <= w_operand;
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_mem_done && (w_op != OP_STA)) begin
            r_acc <= w_alu_y;
            r_z   <= w_alu_z;
            if ((w_op == OP_ADD) || (w_op == OP_SUB)) begin
              r_c <= w_alu_c;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.dmem_req   = w_req;
  assign bus.dmem_we    = w_we;
  assign bus.dmem_addr  = w_operand;
  assign bus.dmem_wdata = r_acc;

  assign pc      = r_pc;
  assign acc     = r_acc;
  assign halted  = w_halted;
  assign illegal = w_illegal;

endmodule

// File: doc/core_mc.md
Name: core_mc

Overview:
- Parametrised multi-cycle accumulator core; successor to the fixed single-configuration `core`.
- Generalised data and address width.
- External synchronous instruction ROM port.
- Data-memory port with a variable-latency req/ack handshake.
- Carry/zero flags with conditional branches, a halt state, an illegal-opcode pulse and global clock-enable stalling.
- Sits at the top of the CPU subsystem and is driven by the system clock, reset and `clk_en`.

Parameters:
- DATA_W, 8, accumulator and data-memory word width (>=4).
- ADDR_W, 8, PC and data address width; instruction word is 4+ADDR_W bits (opcode in the top 4 bits).
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  global enable; 0 freezes all state.
- imem_addr  out  ADDR_W  instruction address, always equal to pc.
- imem_rdata  in  4+ADDR_W  ROM data, valid one cycle after imem_addr (registered ROM).
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read; valid while req.
- dmem_addr  out  ADDR_W  data address; valid while req.
- dmem_wdata  out  DATA_W  write data (= acc); valid while req.
- dmem_rdata  in  DATA_W  read data, valid when ack.
- dmem_ack  in  1  access complete; may be combinational from req.
- pc  out  ADDR_W  program counter.
- acc  out  DATA_W  accumulator.
- halted  out  1  core in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - pc=RESET_PC, acc=0, Z=0, C=0, ir=0
  - state=FETCH, dmem_req=0, dmem_we=0, halted=0, illegal=0
- Reset mid-handshake drops dmem_req immediately.
- clk_en=0:
  - No register or state changes; outputs hold.
  - dmem_ack is ignored; the memory must hold ack until it is sampled with clk_en=1.
- States and transitions:
  - FETCH -> DECODE: ROM address presented.
  - DECODE: ir <= imem_rdata; pc <= pc+1 (wraps mod 2^ADDR_W); -> EXEC.
  - EXEC, non-memory op: execute, then -> FETCH (or -> HALT for HLT).
  - EXEC, memory op: -> MEM.
  - MEM: dmem_req=1 with addr/we/wdata stable. On a cycle with dmem_ack=1 and clk_en=1, complete the op and go -> FETCH; dmem_req is 0 from the next cycle.
  - HALT: absorbing until reset; halted=1; no memory requests.
- Latency:
  - Non-memory instruction: 3 cycles.
  - Memory instruction: 4 cycles with zero-wait ack, plus one cycle per wait state.
- Opcodes (operand a = ir[ADDR_W-1:0]):
  - 0 NOP
  - 1 LDA: acc=M[a]
  - 2 STA: M[a]=acc, flags unchanged
  - 3 ADD: {C,acc}=acc+M[a]
  - 4 SUB: acc=acc-M[a], C=borrow
  - 5 AND, 6 OR, 7 XOR: acc op M[a], C unchanged
  - 8 LDI: acc=a zero-extended, or truncated to DATA_W
  - 9 JMP: pc=a
  - A JZ: pc=a if Z
  - B JC: pc=a if C
  - F HLT
  - C, D, E: behave as NOP and pulse illegal in EXEC.
- Flags:
  - Z = (acc==0) after every acc write.
  - C is written only by ADD and SUB.
  - A taken branch overrides the incremented pc.
- Arithmetic is modulo 2^DATA_W; carry is bit DATA_W of the (DATA_W+1)-bit sum or difference.

Decomposition:
- Package core_pkg holds:
  - OP_W=4 and the opcode enum (OP_NOP..OP_HLT).
  - The state enum (S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT).
  - A helper function is_mem_op.
- Sub-module core_alu: combinational; inputs op, a, b; outputs y, carry, zero. Parametrised by DATA_W.
- The FSM, registers and handshake stay in core_mc.

Test Plan:
- Reset/stall:
  - Assert rst=0 mid-run: pc=0, acc=0, req=0 immediately.
  - Release reset with clk_en=0 for 5 cycles: pc stays 0, no imem_addr change.
  - Set clk_en=1: first ir latched 2 cycles later.
- Arithmetic/flags: ROM LDI 0xFF; STA 0x10; LDI 0x01; ADD 0x10; JC 0x20 with zero-wait ack -> acc=0x00, Z=1, C=1, pc=0x20 at next FETCH.
- Handshake: LDA 0x05 with ack delayed 3 cycles and M[5]=0xA5 -> dmem_req high for exactly 4 cycles, addr=0x05, we=0; acc=0xA5 after; instruction takes 7 cycles.
- clk_en dropped during MEM with ack=1 -> no completion; req stays high; completes on the first cycle with clk_en=1.
- Illegal/halt: opcode 0xC -> illegal high for one cycle, acc unchanged. HLT -> halted=1, pc frozen, no further req for 20 cycles.
- Wrap/parameters: ADDR_W=4, PC at 0xF executing NOP -> pc=0x0. DATA_W=16: SUB 1 from 0 -> acc=0xFFFF, C=1, Z=0.
